// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: round-robin sharing of one synchronous image ROM between two pixel requesters.
// Latency: grant is combinational; rd_valid/rd_rgb appear ROM_LATENCY+2 cycles after the grant.
// Backpressure: none inside; a requester holds req/addr stable until it sees its gnt.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/addr0/gnt0     requester 0 request, address {y[5:0],x[5:0]}, combinational grant
//   rd_valid0/rd_rgb0   registered one-cycle return pulse and RGB for requester 0
//   req1 ... rd_rgb1    same for requester 1
//   rom_address         registered ROM address
//   rom_rgb             ROM data, valid ROM_LATENCY cycles after rom_address changes
module image_rom_arbiter #(
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [11:0] addr0,
  output logic        gnt0,
  output logic        rd_valid0,
  output logic [11:0] rd_rgb0,
  input  logic        req1,
  input  logic [11:0] addr1,
  output logic        gnt1,
  output logic        rd_valid1,
  output logic [11:0] rd_rgb1,
  output logic [11:0] rom_address,
  input  logic [11:0] rom_rgb
);

  // Tracking pipeline depth: one stage for the address register plus the ROM latency.
  localparam int PL = ROM_LATENCY + 1;

  logic          last_id_q, last_id_d;
  logic [11:0]   rom_address_q, rom_address_d;
  logic [PL-1:0] vld_q, vld_d;
  logic [PL-1:0] id_q, id_d;
  logic          rd_valid0_q, rd_valid0_d;
  logic          rd_valid1_q, rd_valid1_d;
  logic [11:0]   rd_rgb0_q, rd_rgb0_d;
  logic [11:0]   rd_rgb1_q, rd_rgb1_d;

  logic gnt0_c, gnt1_c, any_gnt;
  logic exit0, exit1;

  // Arbitration. last_id_q=1 means requester 1 won last, so requester 0 wins a tie.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        gnt0_c = last_id_q;
        gnt1_c = ~last_id_q;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
  end

  assign any_gnt = gnt0_c | gnt1_c;

  // A tracked read leaves the last stage in the same cycle its ROM data is valid.
  assign exit0 = vld_q[PL-1] & ~id_q[PL-1];
  assign exit1 = vld_q[PL-1] &  id_q[PL-1];

  always_comb begin
    last_id_d     = last_id_q;
    rom_address_d = rom_address_q;
    if (any_gnt) begin
      last_id_d     = gnt1_c;
      rom_address_d = gnt1_c ? addr1 : addr0;
    end
    // Pure shift with no stall: entry and exit in one cycle are both handled.
    vld_d       = {vld_q[PL-2:0], any_gnt};
    id_d        = {id_q[PL-2:0], gnt1_c};
    rd_valid0_d = exit0;
    rd_valid1_d = exit1;
    rd_rgb0_d   = exit0 ? rom_rgb : rd_rgb0_q;
    rd_rgb1_d   = exit1 ? rom_rgb : rd_rgb1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q     <= 1'b1;
      rom_address_q <= '0;
      vld_q         <= '0;
      id_q          <= '0;
      rd_valid0_q   <= 1'b0;
      rd_valid1_q   <= 1'b0;
      rd_rgb0_q     <= '0;
      rd_rgb1_q     <= '0;
    end else begin
      last_id_q     <= last_id_d;
      rom_address_q <= rom_address_d;
      vld_q         <= vld_d;
      id_q          <= id_d;
      rd_valid0_q   <= rd_valid0_d;
      rd_valid1_q   <= rd_valid1_d;
      rd_rgb0_q     <= rd_rgb0_d;
      rd_rgb1_q     <= rd_rgb1_d;
    end
  end

  assign gnt0        = gnt0_c;
  assign gnt1        = gnt1_c;
  assign rom_address = rom_address_q;
  assign rd_valid0   = rd_valid0_q;
  assign rd_valid1   = rd_valid1_q;
  assign rd_rgb0     = rd_rgb0_q;
  assign rd_rgb1     = rd_rgb1_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Bench for image_rom_arbiter: two instances (ROM latency 1 and 3) share one stimulus stream.
// Directed scenarios followed by randomized requests with occasional resets.
// Expected reads are queued at grant time and retired by an independent output monitor.
module tb_image_rom_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    logic [11:0] rgb;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [11:0] addr0, addr1;

  logic        gnt_w  [2][2];
  logic        rdv    [2][2];
  logic [11:0] rgbo   [2][2];
  logic [11:0] raddr  [2];
  logic [11:0] rrgb   [2];

  logic [11:0] mem [4096];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  exp_t        sbq [2][2][$];
  logic [11:0] exp_rgb [2][2];
  logic [11:0] exp_addr;
  int          last_id;
  bit          g_prev;
  logic [11:0] a_prev;

  image_rom_arbiter #(.ROM_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt_w[0][0]), .rd_valid0(rdv[0][0]), .rd_rgb0(rgbo[0][0]),
    .req1(req1), .addr1(addr1), .gnt1(gnt_w[0][1]), .rd_valid1(rdv[0][1]), .rd_rgb1(rgbo[0][1]),
    .rom_address(raddr[0]), .rom_rgb(rrgb[0])
  );

  image_rom_arbiter #(.ROM_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt_w[1][0]), .rd_valid0(rdv[1][0]), .rd_rgb0(rgbo[1][0]),
    .req1(req1), .addr1(addr1), .gnt1(gnt_w[1][1]), .rd_valid1(rdv[1][1]), .rd_rgb1(rgbo[1][1]),
    .rom_address(raddr[1]), .rom_rgb(rrgb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM models: first register reads the array, extra stages add latency.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rom
    logic [11:0] d [4];
    always @(posedge clk) begin
      d[0] <= mem[raddr[gi]];
      for (int k = 1; k < 4; k++) d[k] <= d[k-1];
    end
    assign rrgb[gi] = d[((gi == 0) ? LAT0 : LAT1) - 1];
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // One clock cycle of stimulus; returns the model's expected grant (-1 none).
  task automatic step(input bit rst_v, input bit r0, input logic [11:0] a0,
                      input bit r1, input logic [11:0] a1, output int gid);
    logic [1:0] want;
    @(posedge clk);
    if (g_prev) exp_addr = a_prev;
    g_prev = 1'b0;
    #1;
    rst_n = rst_v;
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
    if (!rst_v) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++) begin
          sbq[i][r].delete();
          exp_rgb[i][r] = '0;
        end
      last_id  = 1;
      exp_addr = '0;
    end
    @(negedge clk);
    gid = -1;
    if (rst_v) begin
      if (r0 && r1) gid = 1 - last_id;
      else if (r0)  gid = 0;
      else if (r1)  gid = 1;
    end
    want = {gid == 1, gid == 0};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({gnt_w[i][1], gnt_w[i][0]} !== want) begin
        errors++;
        $display("FAIL gnt inst%0d cyc %0d: got %b%b want %b", i, cyc, gnt_w[i][1], gnt_w[i][0], want);
      end
    end
    if (gid >= 0) begin
      last_id = gid;
      g_prev  = 1'b1;
      a_prev  = (gid == 1) ? a1 : a0;
      for (int i = 0; i < 2; i++)
        sbq[i][gid].push_back('{rgb: mem[a_prev], due: cyc + 2 + lat_of(i)});
    end
  endtask

  // Output monitor: retires expected reads whenever the DUT presents rd_valid.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (rdv[i][r] === 1'b1) begin
          checks++;
          if (sbq[i][r].size() == 0) begin
            errors++;
            $display("FAIL spurious rd_valid%0d inst%0d cyc %0d: got rgb %h want no read", r, i, cyc, rgbo[i][r]);
          end else begin
            e = sbq[i][r].pop_front();
            exp_rgb[i][r] = e.rgb;
            if (e.due != cyc || rgbo[i][r] !== e.rgb) begin
              errors++;
              $display("FAIL read%0d inst%0d: got rgb %h at cyc %0d want rgb %h at cyc %0d",
                       r, i, rgbo[i][r], cyc, e.rgb, e.due);
            end
          end
        end else begin
          checks++;
          if (rdv[i][r] !== 1'b0 || rgbo[i][r] !== exp_rgb[i][r]) begin
            errors++;
            $display("FAIL hold%0d inst%0d cyc %0d: got valid %b rgb %h want valid 0 rgb %h",
                     r, i, cyc, rdv[i][r], rgbo[i][r], exp_rgb[i][r]);
          end
          if (sbq[i][r].size() > 0 && sbq[i][r][0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing read%0d inst%0d cyc %0d: got no valid want rgb %h",
                     r, i, cyc, sbq[i][r][0].rgb);
            void'(sbq[i][r].pop_front());
          end
        end
      end
      checks++;
      if (raddr[i] !== exp_addr) begin
        errors++;
        $display("FAIL rom_address inst%0d cyc %0d: got %h want %h", i, cyc, raddr[i], exp_addr);
      end
    end
  end

  initial begin
    int          gid;
    bit          p0, p1;
    logic [11:0] pa0, pa1;
    for (int k = 0; k < 4096; k++) mem[k] = 12'($urandom);
    mem[12'h041] = 12'hABC;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++) exp_rgb[i][r] = '0;
    exp_addr = '0;
    last_id  = 1;
    g_prev   = 1'b0;
    a_prev   = '0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    // Reset state, with requests high to confirm grants are suppressed.
    step(1'b0, 1'b1, 12'h123, 1'b1, 12'h456, gid);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Single read at 0x041.
    step(1'b1, 1'b1, 12'h041, 1'b0, 12'h000, gid);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Contention straight after reset: grants must alternate starting with 0.
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, gid);
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, 12'(12'h100 + k / 2), 1'b1, 12'(12'h200 + k / 2), gid);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Solo streaming on requester 1, including the top address.
    step(1'b1, 1'b0, 12'h000, 1'b1, 12'h000, gid);
    step(1'b1, 1'b0, 12'h000, 1'b1, 12'h001, gid);
    step(1'b1, 1'b0, 12'h000, 1'b1, 12'h002, gid);
    step(1'b1, 1'b0, 12'h000, 1'b1, 12'hFFF, gid);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Reset while a read is in flight.
    step(1'b1, 1'b1, 12'h155, 1'b0, 12'h000, gid);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, gid);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, gid);
    step(1'b1, 1'b1, 12'h0AA, 1'b0, 12'h000, gid);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Single read on requester 1 (exercises the long-latency instance too).
    step(1'b1, 1'b0, 12'h000, 1'b1, 12'h7E0, gid);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Idle.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);

    // Random traffic: requests persist with a stable address until granted.
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0;
    for (int k = 0; k < 600; k++) begin
      if (!p0 && $urandom_range(99) < 60) begin
        p0  = 1'b1;
        pa0 = ($urandom_range(9) == 0) ? 12'hFFF : 12'($urandom);
      end
      if (!p1 && $urandom_range(99) < 60) begin
        p1  = 1'b1;
        pa1 = ($urandom_range(9) == 0) ? 12'hFFF : 12'($urandom);
      end
      if ($urandom_range(99) < 2) begin
        step(1'b0, p0, pa0, p1, pa1, gid);
      end else begin
        step(1'b1, p0, pa0, p1, pa1, gid);
        if (gid == 0) p0 = 1'b0;
        if (gid == 1) p1 = 1'b0;
      end
    end

    // Drain and confirm every issued read came back.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, gid);
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++) begin
        checks++;
        if (sbq[i][r].size() != 0) begin
          errors++;
          $display("FAIL drain%0d inst%0d: got %0d outstanding want 0", r, i, sbq[i][r].size());
        end
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_rom_arbiter.md
# image_rom_arbiter

Round-robin arbiter that shares one synchronous image ROM (12-bit address, 12-bit RGB, fixed read latency) between two pixel requesters, e.g. two sprite draw units in the VGA pipeline. It grants at most one request per cycle and drives the ROM address register. It tracks in-flight reads through a valid/ID pipeline and returns each RGB word to the requester that issued it, with fixed latency and full throughput.

## Interface

- ROM_LATENCY, 1, ROM read latency in cycles from a registered address to valid `rom_rgb`; legal 1..4.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 read request; held with `addr0` stable until granted.
- addr0  input  12  requester 0 address {y[5:0], x[5:0]}.
- gnt0  output  1  combinational grant to requester 0 this cycle.
- rd_valid0  output  1  registered; one-cycle pulse marking `rd_rgb0` valid.
- rd_rgb0  output  12  registered; RGB returned to requester 0.
- req1, addr1, gnt1, rd_valid1, rd_rgb1: same as above, for requester 1.
- rom_address  output  12  registered address to the ROM.
- rom_rgb  input  12  ROM data, valid ROM_LATENCY cycles after `rom_address` changes.

## Operation

- Arbitration is combinational, in the cycle of the request.
  - Only req0 high: gnt0=1. Only req1 high: gnt1=1.
  - Both high: grant goes to the requester not granted last (`last_id`).
  - `gnt0` and `gnt1` are never high together. No request: no grant.
- `last_id` updates on every grant. Reset value is 1, so requester 0 wins the first contention.
- A requester may hold req high across cycles. Each cycle with gnt=1 consumes one address. Back-to-back grants to one requester are legal when the other is idle.
- Issue stage: on a grant, `rom_address` <= selected address. With no grant, `rom_address` holds its value and no read is tracked.
- Tracking pipeline: shift register of {valid, id}, length ROM_LATENCY+1.
  - A stage enters on each grant, with id = winning requester.
  - On exit, the block registers `rom_rgb` into `rd_rgb<id>` and pulses `rd_valid<id>`.
  - The other requester's `rd_rgb` holds its previous value and its valid stays 0.
- Returned data order per requester equals grant order. Reads are never dropped or duplicated outside reset.

## Timing

- Grant in cycle N produces `rom_address` in cycle N+1, ROM data in cycle N+1+ROM_LATENCY, and `rd_valid`/`rd_rgb` in cycle N+2+ROM_LATENCY.
- Total latency is 3 cycles at the default latency.
- Throughput: one read per cycle aggregate. Under continuous contention, grants alternate 0,1,0,1.
- Reset (rst_n=0, asynchronous):
  - `rom_address`=0, `rd_rgb0`=`rd_rgb1`=0, `rd_valid0`=`rd_valid1`=0.
  - All pipeline valids cleared; `last_id`=1.
  - `gnt0`/`gnt1` are forced 0 while rst_n=0.
- Reset mid-operation: in-flight reads are discarded and no `rd_valid` fires for them. After release, the first grant is in the first cycle with rst_n=1 and a request.
- Simultaneous events: a grant entering the pipeline and a read exiting it in the same cycle are both handled. The pipeline is a pure shift, with no stall.
- Address wrap: 12-bit addresses pass through unmodified; 0xFFF is legal.

## Test plan

- Single read: req0 with addr0=0x041 for one cycle, ROM preloaded with rom[0x041]=0xABC, ROM_LATENCY=1.
  - Required: gnt0 in cycle N; `rom_address`=0x041 in N+1; rd_valid0=1 with rd_rgb0=0xABC in N+3; rd_valid1 stays 0.
- Contention after reset: req0 and req1 held high for 6 cycles with distinct addresses.
  - Required: grant sequence 0,1,0,1,0,1.
  - Data returns to the matching requester in the same order, 3 cycles after each grant.
- Solo streaming: req1 high for 4 cycles with addr1 = 0x000, 0x001, 0x002, 0xFFF.
  - Required: gnt1 every cycle.
  - rd_valid1 high for 4 consecutive cycles with rom[0x000..0x002], rom[0xFFF].
- Reset mid-flight: grant req0, then assert rst_n=0 one cycle later for 2 cycles.
  - Required: all outputs 0 immediately; no rd_valid0 after release.
  - The next req0 is granted in the first cycle after release.
- Latency parameter: ROM_LATENCY=3, single req1 at 0x7E0.
  - Required: rd_valid1 exactly 5 cycles after gnt1, carrying rom[0x7E0].
- Idle: no requests for 10 cycles.
  - Required: gnt0=gnt1=0, no rd_valid pulses, `rom_address` unchanged.
